// File: rtl/bus_pkg.sv
// Shared definitions for the CPU/DMA bus arbiter.
//   state_t        - arbiter FSM states
//   MAX_GRANT_DEF  - default max DMA accesses per grant
//   READ_LAT_DEF   - default cycles from accepted DMA read to read data valid
//   CNT_W          - width of the per-grant access counter
package bus_pkg;

    localparam int MAX_GRANT_DEF = 16;
    localparam int READ_LAT_DEF  = 2;
    localparam int CNT_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        GRANT = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/bus_arbiter_rd_pipe.sv
// bus_rd_pipe: READ_LAT-deep shift register tracking accepted DMA reads.
//   clk       in  clock
//   reset     in  synchronous active-high reset, drops all in-flight reads
//   rd_accept in  a DMA read was accepted this cycle
//   rvalid    out read data for the read accepted READ_LAT cycles ago is valid
//   busy      out at least one read is still in flight beyond this cycle
module bus_rd_pipe
    import bus_pkg::*;
#(
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic rd_accept,
    output logic rvalid,
    output logic busy
);

    logic [READ_LAT-1:0] pipe_q;
    logic [READ_LAT-1:0] pipe_d;

    // The last stage is the read being delivered this cycle, so it does not
    // count as outstanding; the arbiter may leave DRAIN on that cycle and
    // cpu_hold still covers the final rvalid.
    generate
        if (READ_LAT == 1) begin : g_single
            always_comb pipe_d = rd_accept;
            assign busy = 1'b0;
        end else begin : g_multi
            always_comb pipe_d = {pipe_q[READ_LAT-2:0], rd_accept};
            assign busy = |pipe_q[READ_LAT-2:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= pipe_d;
    end

    assign rvalid = pipe_q[READ_LAT-1];

endmodule

// File: rtl/bus_arbiter.sv
// CPU/DMA arbiter for a single shared RAM port. The CPU owns the RAM by
// default; a DMA request holds the CPU, waits for it to park, then grants the
// DMA up to MAX_GRANT single-cycle accesses before draining reads and handing
// the bus back. A cooldown flag forces at least one CPU fetch between grants.
//   clk, reset                      clock / synchronous active-high reset
//   cpu_hold  out                   ask CPU to park (HOLD, GRANT, DRAIN)
//   cpu_busy  in                    CPU is parked
//   cpu_addr/cpu_wdata/cpu_write    CPU master bus
//   dma_req   in                    DMA access request (one per cycle)
//   dma_addr/dma_wdata/dma_write    DMA master bus
//   dma_gnt   out                   DMA owns the bus this cycle
//   dma_rvalid out                  RAM read data belongs to a DMA read
//   mem_addr/mem_wdata/mem_write    shared RAM port
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_GRANT = MAX_GRANT_DEF,
    parameter int READ_LAT  = READ_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cpu_hold,
    input  logic        cpu_busy,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_write,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    input  logic        dma_write,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_write
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_GRANT);

    state_t           state_q, state_d;
    logic             cooldown_q, cooldown_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             rd_accept;
    logic             rd_busy;

    assign dma_gnt   = (state_q == GRANT);
    assign cpu_hold  = (state_q != IDLE);
    assign accept    = dma_gnt & dma_req;
    assign rd_accept = accept & ~dma_write;
    assign cnt_inc   = cnt_q + 1'b1;

    bus_rd_pipe #(.READ_LAT(READ_LAT)) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .rd_accept (rd_accept),
        .rvalid    (dma_rvalid),
        .busy      (rd_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cooldown_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cooldown_q <= cooldown_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cooldown_d = cooldown_q;
        cnt_d      = cnt_q;
        // A low cpu_busy means the CPU got a fetch in; the next grant may go.
        if (!cpu_busy) cooldown_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dma_req && !cooldown_q) state_d = HOLD;
            end
            HOLD: begin
                if (cpu_busy) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!dma_req) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MAX_CNT) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Setting cooldown here takes priority over the clear above.
                if (!rd_busy) begin
                    state_d    = IDLE;
                    cooldown_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_write = cpu_write;
        case (state_q)
            HOLD: begin
                mem_write = 1'b0;
            end
            GRANT: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_write = dma_write & dma_req;
            end
            DRAIN: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_write = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int MAXG = 4;
    localparam int RLAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_hold, cpu_busy = 1'b1;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_write = 1'b0;
    logic        dma_req = 1'b0;
    logic [15:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_write = 1'b0;
    logic        dma_gnt, dma_rvalid;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_write;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_GRANT(MAXG), .READ_LAT(RLAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_hold(cpu_hold), .cpu_busy(cpu_busy),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_write(dma_write), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write)
    );

    // Shared RAM with a 2-cycle read pipeline matching READ_LAT.
    logic [15:0] ram [0:1023];
    logic [15:0] rd_q1, mem_rdata;
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr[9:0]] <= mem_wdata;
        rd_q1     <= ram[mem_addr[9:0]];
        mem_rdata <= rd_q1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_busy = 1'b1; dma_req = 1'b0;
        cpu_addr = 16'h1111; cpu_write = 1'b0;
        cyc(); cyc();
        #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b want=0", cpu_hold); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b want=0", dma_gnt); end
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b want=0", dma_rvalid); end
        checks++; if (mem_addr !== 16'h1111) begin errors++; $display("FAIL reset_addr got=%h want=1111", mem_addr); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b want=0", mem_write); end
        reset = 1'b0;
    endtask

    // Grant straight after reset with the CPU still parked; three writes.
    task automatic test_dma_write();
        int n = 0;
        int first = -1;
        bit hold_seen = 0;
        cpu_busy = 1'b1; dma_req = 1'b1; dma_write = 1'b1;
        dma_addr = 16'h0100; dma_wdata = 16'hA5A5;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (dma_gnt && first < 0) first = c;
            if (dma_gnt && dma_req) n++;
            if (cpu_hold) hold_seen = 1;
            cyc();
            if (n == 3) dma_req = 1'b0;
            dma_addr = 16'h0100 + 16'(n);
        end
        checks++; if (first != 2) begin errors++; $display("FAIL first_gnt_lat got=%0d want=2", first); end
        checks++; if (n != 3) begin errors++; $display("FAIL wr_accepts got=%0d want=3", n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ram[10'h100 + 10'(i)] !== 16'hA5A5) begin
                errors++; $display("FAIL wr_ram[%0d] got=%h want=a5a5", i, ram[10'h100 + 10'(i)]);
            end
        end
        checks++; if (!hold_seen) begin errors++; $display("FAIL wr_hold_seen got=0 want=1"); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL wr_hold_drop got=%b want=0", cpu_hold); end
    endtask

    // CPU mid-instruction: its store lands, then DMA waits for cpu_busy.
    task automatic test_cpu_store();
        dma_req = 1'b0; cpu_busy = 1'b0;
        cyc();
        cpu_addr = 16'h0080; cpu_wdata = 16'h1234; cpu_write = 1'b1;
        dma_req = 1'b1; dma_write = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'hBEEF;
        #1;
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL st_cpu_wr got=%b want=1", mem_write); end
        checks++; if (mem_addr !== 16'h0080) begin errors++; $display("FAIL st_cpu_addr got=%h want=0080", mem_addr); end
        cyc();
        cpu_write = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL st_gnt_wait[%0d] got=%b want=0", c, dma_gnt); end
            checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL st_hold_wait[%0d] got=%b want=1", c, cpu_hold); end
            checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL st_wr_hold[%0d] got=%b want=0", c, mem_write); end
            cyc();
        end
        cpu_busy = 1'b1;
        #1;
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL st_gnt_early got=%b want=0", dma_gnt); end
        cyc();
        #1;
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL st_gnt got=%b want=1", dma_gnt); end
        checks++; if (mem_addr !== 16'h0200) begin errors++; $display("FAIL st_dma_addr got=%h want=0200", mem_addr); end
        cyc();
        dma_req = 1'b0;
        cyc(); cyc(); cyc();
        checks++; if (ram[10'h080] !== 16'h1234) begin errors++; $display("FAIL st_cpu_ram got=%h want=1234", ram[10'h080]); end
        checks++; if (ram[10'h200] !== 16'hBEEF) begin errors++; $display("FAIL st_dma_ram got=%h want=beef", ram[10'h200]); end
    endtask

    // Ten accesses with MAX_GRANT=4: grants of 4, 4, 2 with CPU fetches between.
    task automatic test_max_grant();
        int sent = 0, runs = 0, cur = 0, gaps_ok = 0;
        int lens [3] = '{0, 0, 0};
        bit gap_low = 0, acc;
        dma_req = 1'b0; cpu_busy = 1'b0;
        cyc(); cyc();
        dma_write = 1'b1; dma_addr = 16'h0300; dma_wdata = 16'h3000; dma_req = 1'b1;
        for (int c = 0; c < 60; c++) begin
            cpu_busy = cpu_hold;   // CPU parks when held, fetches otherwise
            #1;
            if (!cpu_busy) gap_low = 1;
            acc = dma_gnt && dma_req;
            if (acc) begin
                if (cur == 0 && runs > 0 && gap_low) gaps_ok++;
                cur++;
            end else if (cur > 0) begin
                if (runs < 3) lens[runs] = cur;
                runs++; cur = 0; gap_low = 0;
            end
            cyc();
            if (acc) sent++;
            dma_req   = (sent < 10);
            dma_addr  = 16'h0300 + 16'(sent);
            dma_wdata = 16'h3000 + 16'(sent);
        end
        checks++; if (runs != 3) begin errors++; $display("FAIL mg_runs got=%0d want=3", runs); end
        checks++; if (lens[0] != 4) begin errors++; $display("FAIL mg_len0 got=%0d want=4", lens[0]); end
        checks++; if (lens[1] != 4) begin errors++; $display("FAIL mg_len1 got=%0d want=4", lens[1]); end
        checks++; if (lens[2] != 2) begin errors++; $display("FAIL mg_len2 got=%0d want=2", lens[2]); end
        checks++; if (gaps_ok != 2) begin errors++; $display("FAIL mg_cpu_gaps got=%0d want=2", gaps_ok); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ram[10'h300 + 10'(i)] !== 16'h3000 + 16'(i)) begin
                errors++; $display("FAIL mg_ram[%0d] got=%h want=%h", i, ram[10'h300 + 10'(i)], 16'h3000 + 16'(i));
            end
        end
    endtask

    // Four reads of preloaded 1..4: back-to-back rvalid, hold until the last.
    task automatic test_reads();
        int sent = 0, nrv = 0, first_acc = -1, first_rv = -1, last_rv = -1;
        bit acc, hold_after = 1'b1;
        dma_req = 1'b0; cpu_busy = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 16'h0010 + 16'(i); cpu_wdata = 16'(i + 1); cpu_write = 1'b1;
            cyc();
        end
        cpu_write = 1'b0; cpu_busy = 1'b1;
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0010;
        for (int c = 0; c < 20; c++) begin
            #1;
            acc = dma_gnt && dma_req;
            if (acc && first_acc < 0) first_acc = c;
            if (last_rv >= 0 && c == last_rv + 1) hold_after = cpu_hold;
            if (dma_rvalid) begin
                if (first_rv < 0) first_rv = c;
                last_rv = c;
                checks++; if (mem_rdata !== 16'(nrv + 1)) begin errors++; $display("FAIL rd_data[%0d] got=%h want=%h", nrv, mem_rdata, 16'(nrv + 1)); end
                checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rd_hold[%0d] got=%b want=1", nrv, cpu_hold); end
                nrv++;
            end
            cyc();
            if (acc) sent++;
            dma_req  = (sent < 4);
            dma_addr = 16'h0010 + 16'(sent);
        end
        checks++; if (nrv != 4) begin errors++; $display("FAIL rd_count got=%0d want=4", nrv); end
        checks++; if (first_rv - first_acc != 2) begin errors++; $display("FAIL rd_latency got=%0d want=2", first_rv - first_acc); end
        checks++; if (last_rv - first_rv != 3) begin errors++; $display("FAIL rd_span got=%0d want=3", last_rv - first_rv); end
        checks++; if (hold_after !== 1'b0) begin errors++; $display("FAIL rd_hold_release got=%b want=0", hold_after); end
    endtask

    // Reset in GRANT with two reads in flight: nothing comes out afterwards.
    task automatic test_reset_mid();
        int sent = 0, rv_seen = 0;
        bit acc;
        dma_req = 1'b0; cpu_busy = 1'b0;
        cyc();
        cpu_busy = 1'b1; dma_req = 1'b1; dma_write = 1'b0; dma_addr = 16'h0010;
        for (int c = 0; c < 10 && sent < 2; c++) begin
            #1;
            acc = dma_gnt && dma_req;
            cyc();
            if (acc) begin sent++; dma_addr = 16'h0010 + 16'(sent); end
        end
        checks++; if (sent != 2) begin errors++; $display("FAIL rm_accepts got=%0d want=2", sent); end
        reset = 1'b1;
        cyc();
        dma_req = 1'b0;
        #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rm_hold got=%b want=0", cpu_hold); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL rm_gnt got=%b want=0", dma_gnt); end
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid got=%b want=0", dma_rvalid); end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (dma_rvalid) rv_seen++;
        end
        checks++; if (rv_seen != 0) begin errors++; $display("FAIL rm_late_rvalid got=%0d want=0", rv_seen); end
    endtask

    // One access then drop: GRANT->DRAIN->IDLE, re-request waits for a CPU fetch.
    task automatic test_drop_one();
        bit got = 0;
        cpu_busy = 1'b1; dma_req = 1'b1; dma_write = 1'b1;
        dma_addr = 16'h0050; dma_wdata = 16'h5555;
        for (int c = 0; c < 6 && !got; c++) begin
            #1;
            if (dma_gnt) got = 1;
            else cyc();
        end
        checks++; if (!got) begin errors++; $display("FAIL dr_gnt_timeout got=0 want=1"); end
        cyc();
        dma_req = 1'b0;
        #1;
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL dr_gnt_after got=%b want=1", dma_gnt); end
        cyc();
        dma_req = 1'b1; dma_addr = 16'h0051;
        #1;
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL dr_drain_gnt got=%b want=0", dma_gnt); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL dr_drain_hold got=%b want=1", cpu_hold); end
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL dr_drain_wr got=%b want=0", mem_write); end
        cyc();
        #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL dr_idle_hold got=%b want=0", cpu_hold); end
        cyc(); cyc();
        #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL dr_cool_hold got=%b want=0", cpu_hold); end
        cpu_busy = 1'b0;
        cyc();
        cpu_busy = 1'b1;
        #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL dr_fetch_hold got=%b want=0", cpu_hold); end
        cyc();
        #1;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL dr_rehold got=%b want=1", cpu_hold); end
        checks++; if (ram[10'h050] !== 16'h5555) begin errors++; $display("FAIL dr_ram got=%h want=5555", ram[10'h050]); end
        dma_req = 1'b0;
        cyc(); cyc(); cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_dma_write();
        test_cpu_store();
        test_max_grant();
        test_reads();
        test_reset_mid();
        test_drop_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
